// File: rtl/lsu_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dmem_pkg
//  Purpose  : Shared load/store controls, FSM states and access-size helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_dmem_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b11
    } ls_type_t;

    localparam logic [1:0] WSEL_MEM = 2'b01;

    typedef enum logic [0:0] {
        LSU_IDLE   = 1'b0,
        LSU_ACCESS = 1'b1
    } lsu_state_t;

    // The reserved encoding 2'b10 behaves as a word access.
    function automatic ls_type_t ls_type_norm(input logic [1:0] t);
        case (t)
            2'b00:   return LS_BYTE;
            2'b01:   return LS_HALF;
            default: return LS_WORD;
        endcase
    endfunction

    function automatic logic [1:0] ls_align(input ls_type_t t, input logic [1:0] a);
        case (t)
            LS_BYTE: return a;
            LS_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic ls_misaligned(input ls_type_t t, input logic [1:0] a);
        case (t)
            LS_BYTE: return 1'b0;
            LS_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bank
//  Purpose  : Four byte-lane data RAM with registered, write-first read port.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rword
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rbyte;

        // A written lane returns the new byte in the same registered word.
        always_ff @(posedge clk) begin
            if (we[i]) begin
                r_mem[widx] <= wdata[8*i +: 8];
                r_rbyte     <= wdata[8*i +: 8];
            end else begin
                r_rbyte     <= r_mem[widx];
            end
        end

        assign rword[8*i +: 8] = r_rbyte;
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dmem
//  Purpose  : Two-cycle load/store unit with private data RAM.
//             Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  ls_type,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    lsu_state_t r_state;
    lsu_state_t w_state_nxt;
    ls_type_t   w_type;
    ls_type_t   r_type;
    logic       w_req;
    logic       w_accept;
    logic       w_mis;
    logic [1:0] w_lane;
    logic [1:0] r_lane;
    logic       r_lu;
    logic       r_is_load;
    logic       r_mis;
    logic [3:0] w_be;
    logic [3:0] w_we;
    logic [31:0] w_bank_wdata;
    logic [31:0] w_rword;
    logic [31:0] w_load;
    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic        w_unused_addr;

    assign w_unused_addr = ^addr[31:AW+2];

    assign w_type   = ls_type_norm(ls_type);
    assign w_req    = mem_read | mem_write;
    assign w_accept = (r_state == LSU_IDLE) && w_req && !rst;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis_sticky;

    assign w_mis  = ls_misaligned(w_type, addr[1:0]);
    assign w_lane = addr[1:0];

    always_ff @(posedge clk) begin
        if (rst)
            r_mis_sticky <= 1'b0;
        else if (w_accept && w_mis)
            r_mis_sticky <= 1'b1;
    end

    assign misaligned = r_mis_sticky;
`else
    assign w_mis      = 1'b0;
    assign w_lane     = ls_align(w_type, addr[1:0]);
    assign misaligned = 1'b0;
`endif

    always_comb begin
        w_be         = 4'b1111;
        w_bank_wdata = wdata;
        case (w_type)
            LS_BYTE: begin
                w_be         = 4'b0001 << w_lane;
                w_bank_wdata = {4{wdata[7:0]}};
            end
            LS_HALF: begin
                w_be         = w_lane[1] ? 4'b1100 : 4'b0011;
                w_bank_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Write wins over read when both are requested.
    assign w_we = (w_accept && mem_write && !w_mis) ? w_be : 4'b0000;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .we    (w_we),
        .widx  (addr[AW+1:2]),
        .wdata (w_bank_wdata),
        .rword (w_rword)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= LSU_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_req)
                    w_state_nxt = LSU_ACCESS;
            end
            LSU_ACCESS: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = LSU_IDLE;
            end
            default: w_state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane    <= 2'b00;
            r_type    <= LS_BYTE;
            r_lu      <= 1'b0;
            r_is_load <= 1'b0;
            r_mis     <= 1'b0;
        end else if (w_accept) begin
            r_lane    <= w_lane;
            r_type    <= w_type;
            r_lu      <= load_unsigned;
            r_is_load <= !mem_write;
            r_mis     <= w_mis;
        end
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_b = w_rword[7:0];
            2'd1:    w_b = w_rword[15:8];
            2'd2:    w_b = w_rword[23:16];
            default: w_b = w_rword[31:24];
        endcase
        w_h = r_lane[1] ? w_rword[31:16] : w_rword[15:0];
        case (r_type)
            LS_BYTE: w_load = {{24{~r_lu & w_b[7]}}, w_b};
            LS_HALF: w_load = {{16{~r_lu & w_h[15]}}, w_h};
            default: w_load = w_rword;
        endcase
    end

    assign rdata = ((r_state == LSU_ACCESS) && r_is_load && !r_mis) ? w_load : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_dmem
//  Purpose  : Self-checking bench for lsu_dmem: vector table, corner
//             sequences and randomized accesses against a byte-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem;

    localparam int MEM_BYTES = 4 * 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  ls_type;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl [MEM_BYTES];
    logic       mdl_mis = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  t;
        logic        lu;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    lsu_dmem #(.DEPTH_WORDS(1024)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ls_type       (ls_type),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .busy          (busy),
        .done          (done),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-addressable reference: sizes 1/2/4, wrap modulo RAM, write wins.
    task automatic model_access(input logic rd, input logic wr, input logic [1:0] t,
                                input logic lu, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] res);
        int size;
        int ea;
        size = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
        ea   = int'(a % MEM_BYTES);
        res  = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((ea % size) != 0) begin
            mdl_mis = 1'b1;
            return;
        end
`else
        ea = ea - (ea % size);
`endif
        if (wr) begin
            for (int i = 0; i < size; i++)
                mdl[ea + i] = 8'(d >> (8 * i));
        end else if (rd) begin
            for (int i = 0; i < size; i++)
                res = res | (32'(mdl[ea + i]) << (8 * i));
            if (!lu && size < 4 && ((res >> (8 * size - 1)) & 32'h1) != 0)
                res = res | (32'hFFFF_FFFF << (8 * size));
        end
    endtask

    // Issues one request in an IDLE cycle and releases it after acceptance.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] t,
                             input logic lu, input logic [31:0] a, input logic [31:0] d,
                             input string nm, output logic [31:0] got,
                             output logic [31:0] mexp);
        @(negedge clk);
        mem_read      = rd;
        mem_write     = wr;
        ls_type       = t;
        load_unsigned = lu;
        addr          = a;
        wdata         = d;
        model_access(rd, wr, t, lu, a, d, mexp);
        @(posedge clk); #1;
        check({nm, " busy"}, {31'b0, busy}, 32'h1);
        check({nm, " done"}, {31'b0, done}, 32'h1);
        check({nm, " misaligned"}, {31'b0, misaligned}, {31'b0, mdl_mis});
        got = rdata;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check({nm, " done_after"}, {30'b0, busy, done}, 32'h0);
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] t, input logic lu,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp,
                       input string nm);
        vec_t v;
        v.rd = rd; v.wr = wr; v.t = t; v.lu = lu; v.a = a; v.d = d; v.exp = exp; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] mexp;
        logic        rd, wr;
        logic [1:0]  t;
        logic [31:0] a;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; ls_type = 2'b00;
        load_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata, 32'h0);
        check("reset busy/done/mis", {29'b0, busy, done, misaligned}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Give the region used below known contents.
        for (int w = 0; w < 64; w++)
            do_access(1'b0, 1'b1, 2'b11, 1'b0, 32'(4 * w), 32'h5000_0000 + 32'(w * 32'h0101_0101),
                      "init", got, mexp);

        add(0, 1, 2'b11, 0, 32'h20, 32'h1122_3344, 32'h0,         "sw 20");
        add(0, 1, 2'b11, 0, 32'h30, 32'hAABB_CCDD, 32'h0,         "sw 30");
        add(0, 1, 2'b11, 0, 32'h10, 32'hDEAD_BEEF, 32'h0,         "sw 10");
        add(1, 0, 2'b11, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, "lw 10");
        add(0, 1, 2'b00, 0, 32'h21, 32'hFFFF_FF80, 32'h0,         "sb 21");
        add(1, 0, 2'b00, 0, 32'h21, 32'h0,         32'hFFFF_FF80, "lb 21");
        add(1, 0, 2'b00, 1, 32'h21, 32'h0,         32'h0000_0080, "lbu 21");
        add(1, 0, 2'b11, 0, 32'h20, 32'h0,         32'h1122_8044, "lw 20");
        add(1, 0, 2'b00, 0, 32'h22, 32'h0,         32'h0000_0022, "lb 22");
        add(0, 1, 2'b01, 0, 32'h32, 32'h1234_8001, 32'h0,         "sh 32");
        add(1, 0, 2'b01, 0, 32'h32, 32'h0,         32'hFFFF_8001, "lh 32");
        add(1, 0, 2'b01, 1, 32'h32, 32'h0,         32'h0000_8001, "lhu 32");
        add(1, 0, 2'b11, 0, 32'h30, 32'h0,         32'h8001_CCDD, "lw 30");
        add(1, 0, 2'b01, 0, 32'h30, 32'h0,         32'hFFFF_CCDD, "lh 30");
        add(1, 0, 2'b01, 1, 32'h30, 32'h0,         32'h0000_CCDD, "lhu 30");
        add(1, 0, 2'b00, 1, 32'h33, 32'h0,         32'h0000_0080, "lbu 33");
        add(1, 0, 2'b10, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, "lw rsvd 10");
        add(1, 0, 2'b11, 0, 32'h1010, 32'h0,       32'hDEAD_BEEF, "lw wrap");
        add(1, 0, 2'b11, 1, 32'h10, 32'h0,         32'hDEAD_BEEF, "lw lu 10");
        add(1, 1, 2'b11, 0, 32'h14, 32'h0BAD_F00D, 32'h0,         "rd+wr 14");
        add(1, 0, 2'b11, 0, 32'h14, 32'h0,         32'h0BAD_F00D, "lw 14");
        add(0, 1, 2'b11, 0, 32'h13, 32'h1234_5678, 32'h0,         "sw 13");
`ifdef LSU_MISALIGN_TRAP_EN
        add(1, 0, 2'b11, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, "lw 10 after mis");
        add(1, 0, 2'b01, 0, 32'h31, 32'h0,         32'h0,         "lh 31");
        add(1, 0, 2'b11, 0, 32'h32, 32'h0,         32'h0,         "lw 32");
`else
        add(1, 0, 2'b11, 0, 32'h10, 32'h0,         32'h1234_5678, "lw 10 after mis");
        add(1, 0, 2'b01, 0, 32'h31, 32'h0,         32'hFFFF_CCDD, "lh 31");
        add(1, 0, 2'b11, 0, 32'h32, 32'h0,         32'h8001_CCDD, "lw 32");
`endif

        foreach (vecs[k]) begin
            do_access(vecs[k].rd, vecs[k].wr, vecs[k].t, vecs[k].lu, vecs[k].a, vecs[k].d,
                      vecs[k].name, got, mexp);
            check({vecs[k].name, " rdata"}, got, vecs[k].exp);
        end

        // Held load: accepted on alternate edges only.
        do_access(0, 1, 2'b11, 0, 32'h40, 32'h5A5A_0F0F, "sw 40", got, mexp);
        @(negedge clk);
        mem_read = 1'b1; ls_type = 2'b11; load_unsigned = 1'b0; addr = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("held lw done", {31'b0, done}, (k % 2 == 0) ? 32'h1 : 32'h0);
            check("held lw rdata", rdata, (k % 2 == 0) ? 32'h5A5A_0F0F : 32'h0);
        end
        @(negedge clk);
        mem_read = 1'b0;

        // Held store: data changed while in ACCESS must not be written.
        @(negedge clk);
        mem_write = 1'b1; ls_type = 2'b11; addr = 32'h44;
        for (int k = 0; k < 4; k++) begin
            wdata = 32'h1111_1111 * 32'(k + 1);
            @(posedge clk);
            @(negedge clk);
        end
        mem_write = 1'b0;
        model_access(0, 1, 2'b11, 0, 32'h44, 32'h3333_3333, mexp);
        do_access(1, 0, 2'b11, 0, 32'h44, 32'h0, "lw 44", got, mexp);
        check("held sw result", got, 32'h3333_3333);

        // Reset during a load's ACCESS cycle.
        do_access(0, 1, 2'b11, 0, 32'h50, 32'hCAFE_F00D, "sw 50", got, mexp);
        @(negedge clk);
        mem_read = 1'b1; ls_type = 2'b11; addr = 32'h50;
        @(posedge clk); #1;
        check("pre-rst rdata", rdata, 32'hCAFE_F00D);
        check("pre-rst misaligned", {31'b0, misaligned}, {31'b0, mdl_mis});
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        check("rst mid rdata", rdata, 32'h0);
        check("rst mid busy/done/mis", {29'b0, busy, done, misaligned}, 32'h0);
        mdl_mis = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_access(1, 0, 2'b11, 0, 32'h50, 32'h0, "lw 50 after rst", got, mexp);
        check("lw 50 after rst rdata", got, 32'hCAFE_F00D);

        // Randomized accesses against the byte model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       begin rd = 1'b0; wr = 1'b1; end
                1:       begin rd = 1'b1; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            t = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                a = a + 32'h1000 * 32'($urandom_range(1, 7));
            do_access(rd, wr, t, 1'($urandom_range(0, 1)), a, $urandom, "rand", got, mexp);
            check("rand rdata", got, mexp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
